// File: rtl/alu_ctrl_exme_pkg.sv
// alu_ctrl_exme_pkg
// Shared constants for the ALU / decoder / EX-ME slice:
//   - ALU operation codes driven on alu_op / ctrl_alu
//   - MIPS-style opcode and R-type funct values
//   - alusrca / alusrcb / branch select encodings
//   - ctrl_t bundle used by the decoder, plus helpers for the common shapes
package alu_ctrl_exme_pkg;

  // ALU operation codes; 11..15 are unused and make the ALU output zero
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Operand / branch select encodings
  localparam logic [1:0] SRCA_RS      = 2'd0;
  localparam logic [1:0] SRCA_CONST16 = 2'd1;
  localparam logic [1:0] SRCA_SHAMT   = 2'd2;
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_IMM     = 2'd1;
  localparam logic [1:0] BR_NONE      = 2'b00;
  localparam logic [1:0] BR_EQ        = 2'b01;
  localparam logic [1:0] BR_NE        = 2'b10;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] branch;
    logic       regdst;
    logic       mem2reg;
    logic       ext;
    logic       regwr;
    logic       memwr;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Register-register ALU instruction: writes rd, operand B is rt
  function automatic ctrl_t rtypeCtrl(input logic [3:0] alu, input logic [1:0] srca);
    ctrl_t c;
    c         = CTRL_NOP;
    c.alu     = alu;
    c.alusrca = srca;
    c.alusrcb = SRCB_RT;
    c.regdst  = 1'b1;
    c.regwr   = 1'b1;
    return c;
  endfunction

  // Immediate ALU instruction: writes rt, operand B is the extended immediate
  function automatic ctrl_t immCtrl(input logic [3:0] alu, input logic ext);
    ctrl_t c;
    c         = CTRL_NOP;
    c.alu     = alu;
    c.alusrcb = SRCB_IMM;
    c.ext     = ext;
    c.regwr   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_exme_if.sv
// alu_ctrl_exme_if
// Bundles every non-clock/reset signal of alu_ctrl_exme.
//   decode : op, funct in; ctrl_* out
//   alu    : alu_a, alu_b, alu_op in; alu_out out
//   ex     : ex_wdata, ex_wreg, ex_mem2reg, ex_memwr, ex_regwr in
//   me     : me_alu_out, me_wdata, me_wreg, me_mem2reg, me_memwr, me_regwr out
// master = the side driving instructions/operands, slave = the design.
interface alu_ctrl_exme_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [3:0]  ctrl_alu;
  logic        ctrl_regdst;
  logic        ctrl_mem2reg;
  logic        ctrl_ext;
  logic        ctrl_regwr;
  logic        ctrl_memwr;
  logic        ctrl_jump;
  logic [1:0]  ctrl_alusrca;
  logic [1:0]  ctrl_alusrcb;
  logic [1:0]  ctrl_branch;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_wreg;
  logic        ex_mem2reg;
  logic        ex_memwr;
  logic        ex_regwr;
  logic [31:0] me_alu_out;
  logic [31:0] me_wdata;
  logic [4:0]  me_wreg;
  logic        me_mem2reg;
  logic        me_memwr;
  logic        me_regwr;

  modport master (
    output op, funct, alu_a, alu_b, alu_op,
           ex_wdata, ex_wreg, ex_mem2reg, ex_memwr, ex_regwr,
    input  ctrl_alu, ctrl_regdst, ctrl_mem2reg, ctrl_ext, ctrl_regwr, ctrl_memwr,
           ctrl_jump, ctrl_alusrca, ctrl_alusrcb, ctrl_branch, alu_out,
           me_alu_out, me_wdata, me_wreg, me_mem2reg, me_memwr, me_regwr
  );

  modport slave (
    input  op, funct, alu_a, alu_b, alu_op,
           ex_wdata, ex_wreg, ex_mem2reg, ex_memwr, ex_regwr,
    output ctrl_alu, ctrl_regdst, ctrl_mem2reg, ctrl_ext, ctrl_regwr, ctrl_memwr,
           ctrl_jump, ctrl_alusrca, ctrl_alusrcb, ctrl_branch, alu_out,
           me_alu_out, me_wdata, me_wreg, me_mem2reg, me_memwr, me_regwr
  );
endinterface

// File: rtl/alu_unit.sv
// alu_unit
// Purely combinational 32-bit ALU.
//   i_a, i_b : operands (shifts move i_b by i_a[4:0])
//   i_op     : operation code from alu_ctrl_exme_pkg
//   o_result : result; unused op codes give zero
module alu_unit
  import alu_ctrl_exme_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_op,
  output logic [31:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_a[4:0];

  // Result select. ADD/SUB simply wrap; no overflow detection exists.
  always_comb begin
    o_result = 32'd0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
      ALU_SLTU: o_result = (i_a < i_b) ? 32'd1 : 32'd0;
      ALU_SLL:  o_result = i_b << w_shamt;
      ALU_SRL:  o_result = i_b >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_b) >>> w_shamt);
      default:  o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Combinational main/ALU control decoder.
//   i_op, i_funct : instruction bits [31:26] and [5:0]
//   o_*           : datapath controls; unknown encodings give all-zero (NOP)
module ctrl_decode
  import alu_ctrl_exme_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_branch,
  output logic       o_regdst,
  output logic       o_mem2reg,
  output logic       o_ext,
  output logic       o_regwr,
  output logic       o_memwr,
  output logic       o_jump
);

  ctrl_t w_ctrl;

  // Opcode first, funct only for R-type. Anything unrecognised stays at
  // CTRL_NOP, whose ALU field is ADD (0).
  always_comb begin
    w_ctrl = CTRL_NOP;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD, FN_ADDU: w_ctrl = rtypeCtrl(ALU_ADD,  SRCA_RS);
          FN_SUB, FN_SUBU: w_ctrl = rtypeCtrl(ALU_SUB,  SRCA_RS);
          FN_AND:          w_ctrl = rtypeCtrl(ALU_AND,  SRCA_RS);
          FN_OR:           w_ctrl = rtypeCtrl(ALU_OR,   SRCA_RS);
          FN_XOR:          w_ctrl = rtypeCtrl(ALU_XOR,  SRCA_RS);
          FN_NOR:          w_ctrl = rtypeCtrl(ALU_NOR,  SRCA_RS);
          FN_SLT:          w_ctrl = rtypeCtrl(ALU_SLT,  SRCA_RS);
          FN_SLTU:         w_ctrl = rtypeCtrl(ALU_SLTU, SRCA_RS);
          FN_SLL:          w_ctrl = rtypeCtrl(ALU_SLL,  SRCA_SHAMT);
          FN_SRL:          w_ctrl = rtypeCtrl(ALU_SRL,  SRCA_SHAMT);
          FN_SRA:          w_ctrl = rtypeCtrl(ALU_SRA,  SRCA_SHAMT);
          default:         w_ctrl = CTRL_NOP;
        endcase
      end
      OP_ADDI, OP_ADDIU: w_ctrl = immCtrl(ALU_ADD,  1'b1);
      OP_SLTI:           w_ctrl = immCtrl(ALU_SLT,  1'b1);
      OP_SLTIU:          w_ctrl = immCtrl(ALU_SLTU, 1'b1);
      OP_ANDI:           w_ctrl = immCtrl(ALU_AND,  1'b0);
      OP_ORI:            w_ctrl = immCtrl(ALU_OR,   1'b0);
      OP_XORI:           w_ctrl = immCtrl(ALU_XOR,  1'b0);
      OP_LUI: begin
        // LUI is "imm << 16": operand A is forced to the constant 16
        w_ctrl         = immCtrl(ALU_SLL, 1'b0);
        w_ctrl.alusrca = SRCA_CONST16;
      end
      OP_LW: begin
        w_ctrl         = immCtrl(ALU_ADD, 1'b1);
        w_ctrl.mem2reg = 1'b1;
      end
      OP_SW: begin
        w_ctrl         = immCtrl(ALU_ADD, 1'b1);
        w_ctrl.regwr   = 1'b0;
        w_ctrl.memwr   = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.alu    = ALU_SUB;
        w_ctrl.ext    = 1'b1;
        w_ctrl.branch = BR_EQ;
      end
      OP_BNE: begin
        w_ctrl.alu    = ALU_SUB;
        w_ctrl.ext    = 1'b1;
        w_ctrl.branch = BR_NE;
      end
      OP_J:    w_ctrl.jump = 1'b1;
      default: w_ctrl = CTRL_NOP;
    endcase
  end

  assign o_alu     = w_ctrl.alu;
  assign o_alusrca = w_ctrl.alusrca;
  assign o_alusrcb = w_ctrl.alusrcb;
  assign o_branch  = w_ctrl.branch;
  assign o_regdst  = w_ctrl.regdst;
  assign o_mem2reg = w_ctrl.mem2reg;
  assign o_ext     = w_ctrl.ext;
  assign o_regwr   = w_ctrl.regwr;
  assign o_memwr   = w_ctrl.memwr;
  assign o_jump    = w_ctrl.jump;

endmodule

// File: rtl/exme_reg.sv
// exme_reg
// EX/ME pipeline register: one-cycle delay, no enable, no stall.
//   clk, rst                : clock, asynchronous active-low clear
//   i_alu_out .. i_regwr    : EX-stage values
//   o_alu_out .. o_regwr    : registered ME-stage values
module exme_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_wreg,
  input  logic        i_mem2reg,
  input  logic        i_memwr,
  input  logic        i_regwr,
  output logic [31:0] o_alu_out,
  output logic [31:0] o_wdata,
  output logic [4:0]  o_wreg,
  output logic        o_mem2reg,
  output logic        o_memwr,
  output logic        o_regwr
);

  logic [31:0] r_aluOut;
  logic [31:0] r_wdata;
  logic [4:0]  r_wreg;
  logic        r_mem2reg;
  logic        r_memwr;
  logic        r_regwr;

  // Capture every edge; reset clears immediately so no stale write-enable
  // can leak into the ME stage while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aluOut  <= 32'd0;
      r_wdata   <= 32'd0;
      r_wreg    <= 5'd0;
      r_mem2reg <= 1'b0;
      r_memwr   <= 1'b0;
      r_regwr   <= 1'b0;
    end else begin
      r_aluOut  <= i_alu_out;
      r_wdata   <= i_wdata;
      r_wreg    <= i_wreg;
      r_mem2reg <= i_mem2reg;
      r_memwr   <= i_memwr;
      r_regwr   <= i_regwr;
    end
  end

  assign o_alu_out = r_aluOut;
  assign o_wdata   = r_wdata;
  assign o_wreg    = r_wreg;
  assign o_mem2reg = r_mem2reg;
  assign o_memwr   = r_memwr;
  assign o_regwr   = r_regwr;

endmodule

// File: rtl/alu_ctrl_exme.sv
// alu_ctrl_exme
// Top of the execute slice: control decoder, ALU and EX/ME register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (only affects the EX/ME register)
//   bus  : alu_ctrl_exme_if.slave carrying decode, ALU, EX and ME signals
// The ALU result feeds the EX/ME register directly inside this block.
module alu_ctrl_exme
  import alu_ctrl_exme_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_ctrl_exme_if.slave   bus
);

  logic [31:0] w_aluOut;

  ctrl_decode u_ctrl_decode (
    .i_op      (bus.op),
    .i_funct   (bus.funct),
    .o_alu     (bus.ctrl_alu),
    .o_alusrca (bus.ctrl_alusrca),
    .o_alusrcb (bus.ctrl_alusrcb),
    .o_branch  (bus.ctrl_branch),
    .o_regdst  (bus.ctrl_regdst),
    .o_mem2reg (bus.ctrl_mem2reg),
    .o_ext     (bus.ctrl_ext),
    .o_regwr   (bus.ctrl_regwr),
    .o_memwr   (bus.ctrl_memwr),
    .o_jump    (bus.ctrl_jump)
  );

  alu_unit u_alu_unit (
    .i_a      (bus.alu_a),
    .i_b      (bus.alu_b),
    .i_op     (bus.alu_op),
    .o_result (w_aluOut)
  );

  assign bus.alu_out = w_aluOut;

  exme_reg u_exme_reg (
    .clk       (clk),
    .rst       (rst),
    .i_alu_out (w_aluOut),
    .i_wdata   (bus.ex_wdata),
    .i_wreg    (bus.ex_wreg),
    .i_mem2reg (bus.ex_mem2reg),
    .i_memwr   (bus.ex_memwr),
    .i_regwr   (bus.ex_regwr),
    .o_alu_out (bus.me_alu_out),
    .o_wdata   (bus.me_wdata),
    .o_wreg    (bus.me_wreg),
    .o_mem2reg (bus.me_mem2reg),
    .o_memwr   (bus.me_memwr),
    .o_regwr   (bus.me_regwr)
  );

endmodule

// File: tb/tb_alu_ctrl_exme.sv
// tb_alu_ctrl_exme
// Directed bench: a table of decode+ALU vectors with hand-computed results,
// followed by hand-written EX/ME register and asynchronous reset sequences.
module tb_alu_ctrl_exme;
  import alu_ctrl_exme_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_ctrl_exme_if bus ();

  alu_ctrl_exme dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz-style clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [3:0]  aluOp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expOut;
    logic [15:0] expCtrl;
  } vec_t;

  vec_t vecs[$];

  // Expected control word: {alu, srca, srcb, branch, regdst, mem2reg, ext, regwr, memwr, jump}
  function automatic logic [15:0] mkCtrl(input logic [3:0] alu, input logic [1:0] srca,
                                         input logic [1:0] srcb, input logic [1:0] br,
                                         input logic regdst, input logic m2r, input logic ext,
                                         input logic regwr, input logic memwr, input logic jump);
    return {alu, srca, srcb, br, regdst, m2r, ext, regwr, memwr, jump};
  endfunction

  function automatic logic [15:0] gotCtrl();
    return {bus.ctrl_alu, bus.ctrl_alusrca, bus.ctrl_alusrcb, bus.ctrl_branch,
            bus.ctrl_regdst, bus.ctrl_mem2reg, bus.ctrl_ext, bus.ctrl_regwr,
            bus.ctrl_memwr, bus.ctrl_jump};
  endfunction

  task automatic addVec(input string name, input logic [5:0] op, input logic [5:0] funct,
                        input logic [3:0] aluOp, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expOut, input logic [15:0] expCtrl);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.aluOp = aluOp;
    v.a = a; v.b = b; v.expOut = expOut; v.expCtrl = expCtrl;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic [3:0] aluOp, input logic [31:0] a,
                               input logic [31:0] b);
    bus.op     = op;
    bus.funct  = funct;
    bus.alu_op = aluOp;
    bus.alu_a  = a;
    bus.alu_b  = b;
  endtask

  task automatic applyEx(input logic [31:0] wdata, input logic [4:0] wreg,
                         input logic m2r, input logic memwr, input logic regwr);
    bus.ex_wdata   = wdata;
    bus.ex_wreg    = wreg;
    bus.ex_mem2reg = m2r;
    bus.ex_memwr   = memwr;
    bus.ex_regwr   = regwr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkMe(input string tag, input logic [31:0] aluOut, input logic [31:0] wdata,
                         input logic [4:0] wreg, input logic [2:0] flags);
    checkOutput({tag, " me_alu_out"}, bus.me_alu_out, aluOut);
    checkOutput({tag, " me_wdata"}, bus.me_wdata, wdata);
    checkOutput({tag, " me_wreg"}, {27'd0, bus.me_wreg}, {27'd0, wreg});
    checkOutput({tag, " me_flags"}, {29'd0, bus.me_mem2reg, bus.me_memwr, bus.me_regwr},
                {29'd0, flags});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    applyStimulus(6'h00, 6'h20, 4'd0, 32'd0, 32'd0);
    applyEx(32'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // name, op, funct, aluOp, a, b, expOut, expCtrl
    addVec("add wrap",  6'h00, 6'h20, 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000,
           mkCtrl(4'd0, 2'd0, 2'd0, 2'b00, 1, 0, 0, 1, 0, 0));
    addVec("sub wrap",  6'h00, 6'h22, 4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF,
           mkCtrl(4'd1, 2'd0, 2'd0, 2'b00, 1, 0, 0, 1, 0, 0));
    addVec("slt",       6'h00, 6'h2A, 4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001,
           mkCtrl(4'd6, 2'd0, 2'd0, 2'b00, 1, 0, 0, 1, 0, 0));
    addVec("sltu",      6'h00, 6'h2B, 4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000,
           mkCtrl(4'd7, 2'd0, 2'd0, 2'b00, 1, 0, 0, 1, 0, 0));
    addVec("sra",       6'h00, 6'h03, 4'd10, 32'h00000004, 32'h80000000, 32'hF8000000,
           mkCtrl(4'd10, 2'd2, 2'd0, 2'b00, 1, 0, 0, 1, 0, 0));
    addVec("sll rtype", 6'h00, 6'h00, 4'd10, 32'h00000021, 32'h7FFFFFFE, 32'h3FFFFFFF,
           mkCtrl(4'd8, 2'd2, 2'd0, 2'b00, 1, 0, 0, 1, 0, 0));
    addVec("bad funct", 6'h00, 6'h3F, 4'd11, 32'h00000005, 32'h00000005, 32'h00000000,
           mkCtrl(4'd0, 2'd0, 2'd0, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("lui",       6'h0F, 6'h00, 4'd8,  32'h00000010, 32'h00001234, 32'h12340000,
           mkCtrl(4'd8, 2'd1, 2'd1, 2'b00, 0, 0, 0, 1, 0, 0));
    addVec("lw",        6'h23, 6'h00, 4'd0,  32'h00000100, 32'hFFFFFFFC, 32'h000000FC,
           mkCtrl(4'd0, 2'd0, 2'd1, 2'b00, 0, 1, 1, 1, 0, 0));
    addVec("sw",        6'h2B, 6'h00, 4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,
           mkCtrl(4'd0, 2'd0, 2'd1, 2'b00, 0, 0, 1, 0, 1, 0));
    addVec("bne",       6'h05, 6'h00, 4'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0,
           mkCtrl(4'd1, 2'd0, 2'd0, 2'b10, 0, 0, 1, 0, 0, 0));
    addVec("beq",       6'h04, 6'h00, 4'd4,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00,
           mkCtrl(4'd1, 2'd0, 2'd0, 2'b01, 0, 0, 1, 0, 0, 0));
    addVec("bad op",    6'h3F, 6'h20, 4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF,
           mkCtrl(4'd0, 2'd0, 2'd0, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("jump",      6'h02, 6'h00, 4'd9,  32'h00000024, 32'h80000000, 32'h08000000,
           mkCtrl(4'd0, 2'd0, 2'd0, 2'b00, 0, 0, 0, 0, 0, 1));
    addVec("addi",      6'h08, 6'h00, 4'd8,  32'h0000001F, 32'h00000001, 32'h80000000,
           mkCtrl(4'd0, 2'd0, 2'd1, 2'b00, 0, 0, 1, 1, 0, 0));
    addVec("ori",       6'h0D, 6'h00, 4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000,
           mkCtrl(4'd3, 2'd0, 2'd1, 2'b00, 0, 0, 0, 1, 0, 0));
    addVec("slti",      6'h0A, 6'h00, 4'd6,  32'h00000001, 32'hFFFFFFFF, 32'h00000000,
           mkCtrl(4'd6, 2'd0, 2'd1, 2'b00, 0, 0, 1, 1, 0, 0));
    addVec("andi",      6'h0C, 6'h00, 4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE,
           mkCtrl(4'd2, 2'd0, 2'd1, 2'b00, 0, 0, 0, 1, 0, 0));

    // Reset state: EX/ME outputs must be zero while reset is held
    #12;
    checkMe("reset", 32'd0, 32'd0, 5'd0, 3'b000);

    // Combinational decode/ALU table (reset state is irrelevant here)
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].aluOp, vecs[i].a, vecs[i].b);
      #1;
      checkOutput({vecs[i].name, " alu_out"}, bus.alu_out, vecs[i].expOut);
      checkOutput({vecs[i].name, " ctrl"}, {16'd0, gotCtrl()}, {16'd0, vecs[i].expCtrl});
    end

    // First capture after reset release
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(6'h00, 6'h20, 4'd0, 32'd3, 32'd4);
    applyEx(32'hDEADBEEF, 5'd9, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkMe("cap1", 32'd7, 32'hDEADBEEF, 5'd9, 3'b001);

    // New EX values must not appear until the next edge
    #1;
    applyStimulus(6'h00, 6'h22, 4'd1, 32'd10, 32'd3);
    applyEx(32'h12345678, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("hold me_alu_out", bus.me_alu_out, 32'd7);
    checkOutput("hold me_wreg", {27'd0, bus.me_wreg}, 32'd9);
    @(posedge clk); #1;
    checkMe("cap2", 32'd7, 32'h12345678, 5'd5, 3'b110);

    // Load a write-enabled entry, then reset asynchronously mid-cycle
    #1;
    applyStimulus(6'h00, 6'h24, 4'd2, 32'h000000FF, 32'h0000000F);
    applyEx(32'hCAFEF00D, 5'd31, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkMe("cap3", 32'h0000000F, 32'hCAFEF00D, 5'd31, 3'b001);
    #1;
    rst = 1'b0;
    #1;
    checkMe("async rst", 32'd0, 32'd0, 5'd0, 3'b000);
    @(posedge clk); #1;
    checkMe("rst held", 32'd0, 32'd0, 5'd0, 3'b000);

    // Release and capture a=3+b=4 into register 9
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(6'h00, 6'h20, 4'd0, 32'd3, 32'd4);
    applyEx(32'd0, 5'd9, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkMe("post rst", 32'd7, 32'd0, 5'd9, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_exme.md
ALU_CTRL_EXME -- requirements
Module: alu_ctrl_exme

Interface
REQ-001 Parameter: none; all datapath widths fixed (32-bit data, 5-bit register index).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction bits [31:26]; funct  input  6  instruction bits [5:0].
REQ-005 ctrl_alu  output  4; ctrl_regdst, ctrl_mem2reg, ctrl_ext, ctrl_regwr, ctrl_memwr, ctrl_jump  output  1 each; ctrl_alusrca, ctrl_alusrcb, ctrl_branch  output  2 each; all combinational decode of op/funct.
REQ-006 alu_a, alu_b  input  32  ALU operands; alu_op  input  4  operation; alu_out  output  32  combinational result.
REQ-007 ex_wdata  input  32  store data; ex_wreg  input  5  destination register; ex_mem2reg, ex_memwr, ex_regwr  input  1 each  EX-stage controls.
REQ-008 me_alu_out  output  32; me_wdata  output  32; me_wreg  output  5; me_mem2reg, me_memwr, me_regwr  output  1 each  registered EX/ME values.

Function
REQ-009 ALU ops (alu_op): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL, 9 SRL, 10 SRA; 11-15 SHALL produce 0.
REQ-010 ADD/SUB SHALL wrap modulo 2^32; no overflow flag or trap.
REQ-011 SLT/SLTU SHALL output 32'd1 if alu_a < alu_b (signed/unsigned), else 0.
REQ-012 Shifts SHALL shift alu_b by alu_a[4:0]; alu_a[31:5] ignored; SRA sign-fills.
REQ-013 Decoder encodings: alusrca 0=rs, 1=const 16 (LUI), 2=shamt; alusrcb 0=rt, 1=extended imm; ext 0=zero, 1=sign; branch 00 none, 01 BEQ, 10 BNE; regdst 1=rd, 0=rt.
REQ-014 R-type (op 0x00) funct: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU (alusrca 0); 0x00 SLL, 0x02 SRL, 0x03 SRA (alusrca 2); all with regdst 1, regwr 1, alusrcb 0.
REQ-015 I-type: ADDI 0x08/ADDIU 0x09 ADD ext1; SLTI 0x0A SLT ext1; SLTIU 0x0B SLTU ext1; ANDI 0x0C AND, ORI 0x0D OR, XORI 0x0E XOR ext0; LUI 0x0F SLL alusrca 1 ext0; all alusrcb 1, regdst 0, regwr 1.
REQ-016 LW 0x23: ADD, alusrcb 1, ext1, mem2reg 1, regwr 1, regdst 0; SW 0x2B: ADD, alusrcb 1, ext1, memwr 1, regwr 0.
REQ-017 BEQ 0x04 branch 01, BNE 0x05 branch 10, both SUB, ext1, regwr 0, memwr 0; J 0x02 jump 1, regwr 0, memwr 0.
REQ-018 Unknown op or R-type funct SHALL decode as NOP: all control outputs 0, ctrl_alu ADD (0).
REQ-019 EX/ME register SHALL capture alu_out, ex_wdata, ex_wreg, ex_mem2reg, ex_memwr, ex_regwr on every rising clk edge when rst high; latency exactly 1 cycle, no enable, no stall.

Reset
REQ-020 rst low SHALL immediately clear all me_* outputs to 0, independent of clk.
REQ-021 First capture SHALL occur on the first rising edge after rst deasserts; decoder and ALU unaffected by rst.

Structure
REQ-022 Shared package SHALL hold ALU op codes (REQ-009), opcode/funct constants, and alusrca/alusrcb/branch encodings.
REQ-023 Top SHALL instantiate sub-modules alu_unit, ctrl_decode and exme_reg; alu_out feeds exme_reg data input internally.

Verification
REQ-024 alu_op 0, a=32'hFFFFFFFF, b=1 -> alu_out 0; alu_op 1, a=0, b=1 -> 32'hFFFFFFFF.
REQ-025 alu_op 6, a=32'hFFFFFFFF, b=1 -> 1; alu_op 7 same operands -> 0; alu_op 10, a=4, b=32'h80000000 -> 32'hF8000000.
REQ-026 op 0x0F -> ctrl_alu 8, alusrca 1, alusrcb 1, regwr 1; with a=16, b=32'h00001234 -> alu_out 32'h12340000.
REQ-027 op 0x23 -> mem2reg 1, regwr 1, ext 1; op 0x2B -> memwr 1, regwr 0; op 0x05 -> branch 10; op 0x3F -> all controls 0.
REQ-028 rst low mid-run with me_regwr=1 -> all me_* 0 before next edge; after release, a=3,b=4,op 0,ex_wreg 9,ex_regwr 1 -> next edge me_alu_out 7, me_wreg 9, me_regwr 1.
